// File: rtl/t2mi_packets_to_ts.sv
// Receive-side T2-MI depacketiser: parses T2-MI packets, forwards BB-frame data fields as a TS
// byte stream with user-packet start markers, and reports CRC-32/CRC-8/length/continuity status.
module t2mi_packets_to_ts (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       ENA_IN,
  input  logic       SOP_IN,
  output logic [7:0] TS_DATA,
  output logic       TS_ENA,
  output logic       TS_SOP,
  output logic       HEM,
  output logic [7:0] PKT_TYPE,
  output logic [7:0] FRAME_IDX,
  output logic [7:0] PLP_ID,
  output logic [3:0] SUPERFRAME_IDX,
  output logic       PKT_DONE,
  output logic       CRC32_ERR,
  output logic       CRC8_ERR,
  output logic       FMT_ERR,
  output logic       CC_ERR,
  output logic       ABORT,
  output logic [3:0] state_mon
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR    = 4'd1;
  localparam logic [3:0] S_BB_PRE = 4'd2;
  localparam logic [3:0] S_BB_HDR = 4'd3;
  localparam logic [3:0] S_DATA   = 4'd4;
  localparam logic [3:0] S_SKIP   = 4'd5;
  localparam logic [3:0] S_CRC    = 4'd6;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'hD5) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04C11DB7) : {r[30:0], 1'b0};
    return r;
  endfunction

  logic [3:0]  state, cnt;
  logic [7:0]  len_hi, dfl_hi, syncd_hi, crc8, prev_cc, upl_m1;
  logic [12:0] pay_bytes, rem, dcnt, dfl_bytes, sync_off, sop_cnt;
  logic        sop_en, cc_valid, cc_bad;
  logic [31:0] crc32;
  logic [23:0] crc_rx;

  logic [15:0] len_full;
  logic [12:0] pl_bytes_new, avail, dfl_clip, rem_dec;
  logic        short_pl, fmt_bad, sop_fire, mode_nm, mode_hem;
  logic [7:0]  crc8_next;
  logic [31:0] crc32_next, crc32_start;

  assign state_mon = state;

  // NOTE: every always_comb output is assigned unconditionally at the top, so no latch can be inferred.
  always_comb begin
    len_full     = {len_hi, DATA_IN};
    pl_bytes_new = len_full[15:3] + {12'd0, |len_full[2:0]};
    short_pl     = pay_bytes < 13'd13;
    avail        = pay_bytes - 13'd13;
    fmt_bad      = short_pl || (dfl_bytes > avail);
    dfl_clip     = short_pl ? 13'd0 : ((dfl_bytes > avail) ? avail : dfl_bytes);
    rem_dec      = (rem == 13'd0) ? 13'd0 : rem - 13'd1;
    sop_fire     = sop_en && (sop_cnt == 13'd0);
    mode_nm      = (DATA_IN == crc8);
    mode_hem     = (DATA_IN == (crc8 ^ 8'h01));
    crc8_next    = crc8_byte(crc8, DATA_IN);
    crc32_next   = crc32_byte(crc32, DATA_IN);
    crc32_start  = crc32_byte(32'hFFFFFFFF, DATA_IN);
  end

  // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: datapath registers are reset too, so all outputs come up at 0 and no stale count leaks out.
      state <= S_IDLE;       cnt <= '0;          len_hi <= '0;      dfl_hi <= '0;
      syncd_hi <= '0;        crc8 <= '0;         prev_cc <= '0;     upl_m1 <= '0;
      pay_bytes <= '0;       rem <= '0;          dcnt <= '0;        dfl_bytes <= '0;
      sync_off <= '0;        sop_cnt <= '0;      sop_en <= 1'b0;    cc_valid <= 1'b0;
      cc_bad <= 1'b0;        crc32 <= '0;        crc_rx <= '0;
      TS_DATA <= '0;         TS_ENA <= 1'b0;     TS_SOP <= 1'b0;    HEM <= 1'b0;
      PKT_TYPE <= '0;        FRAME_IDX <= '0;    PLP_ID <= '0;      SUPERFRAME_IDX <= '0;
      PKT_DONE <= 1'b0;      CRC32_ERR <= 1'b0;  CRC8_ERR <= 1'b0;  FMT_ERR <= 1'b0;
      CC_ERR <= 1'b0;        ABORT <= 1'b0;
    end else begin
      TS_ENA    <= 1'b0;
      TS_SOP    <= 1'b0;
      PKT_DONE  <= 1'b0;
      CRC32_ERR <= 1'b0;
      CC_ERR    <= 1'b0;
      ABORT     <= 1'b0;
      if (PKT_DONE) begin
        CRC8_ERR <= 1'b0;
        FMT_ERR  <= 1'b0;
      end
      if (ENA_IN) begin
        if (SOP_IN) begin
          // A start marker always opens a new packet; outside IDLE it truncates the current one.
          if (state != S_IDLE) begin
            ABORT    <= 1'b1;
            CRC8_ERR <= 1'b0;
            FMT_ERR  <= 1'b0;
            cc_valid <= 1'b0;
          end
          PKT_TYPE <= DATA_IN;
          crc32    <= crc32_start;
          cnt      <= 4'd1;
          state    <= S_HDR;
        end else begin
          case (state)
            S_HDR: begin
              crc32 <= crc32_next;
              cnt   <= cnt + 4'd1;
              case (cnt)
                4'd1: begin
                  cc_bad   <= cc_valid && (DATA_IN != prev_cc + 8'd1);
                  prev_cc  <= DATA_IN;
                  cc_valid <= 1'b1;
                end
                4'd2: SUPERFRAME_IDX <= DATA_IN[7:4];
                4'd4: len_hi <= DATA_IN;
                4'd5: begin
                  pay_bytes <= pl_bytes_new;
                  rem       <= pl_bytes_new;
                  cnt       <= 4'd0;
                  if (PKT_TYPE == 8'h00)          state <= S_BB_PRE;
                  else if (pl_bytes_new != 13'd0) state <= S_SKIP;
                  else                            state <= S_CRC;
                end
                default: ;
              endcase
            end
            S_BB_PRE: begin
              crc32 <= crc32_next;
              rem   <= rem_dec;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd0) FRAME_IDX <= DATA_IN;
              if (cnt == 4'd1) PLP_ID <= DATA_IN;
              if (cnt == 4'd2) begin
                cnt   <= 4'd0;
                crc8  <= 8'h00;
                state <= S_BB_HDR;
              end
            end
            S_BB_HDR: begin
              crc32 <= crc32_next;
              rem   <= rem_dec;
              crc8  <= crc8_next;
              cnt   <= cnt + 4'd1;
              case (cnt)
                4'd4: dfl_hi <= DATA_IN;
                4'd5: dfl_bytes <= {dfl_hi, DATA_IN[7:3]};
                4'd7: syncd_hi <= DATA_IN;
                4'd8: begin
                  sync_off <= {syncd_hi, DATA_IN[7:3]};
                  sop_en   <= ({syncd_hi, DATA_IN} != 16'hFFFF);
                end
                4'd9: begin
                  // crc8 now covers bytes 0-8; the last byte carries it XORed with MODE.
                  HEM      <= !mode_nm && mode_hem;
                  upl_m1   <= (!mode_nm && mode_hem) ? 8'd186 : 8'd187;
                  if (!mode_nm && !mode_hem) CRC8_ERR <= 1'b1;
                  if (fmt_bad) FMT_ERR <= 1'b1;
                  sop_cnt  <= sync_off;
                  dcnt     <= dfl_clip;
                  cnt      <= 4'd0;
                  if (dfl_clip != 13'd0)     state <= S_DATA;
                  else if (rem_dec != 13'd0) state <= S_SKIP;
                  else                       state <= S_CRC;
                end
                default: ;
              endcase
            end
            S_DATA: begin
              crc32   <= crc32_next;
              rem     <= rem_dec;
              dcnt    <= dcnt - 13'd1;
              TS_ENA  <= 1'b1;
              TS_DATA <= DATA_IN;
              TS_SOP  <= sop_fire;
              // Wrapping down-counter marks every upl-th byte from the sync offset onward.
              if (sop_fire)                 sop_cnt <= {5'd0, upl_m1};
              else if (sop_cnt != 13'd0)    sop_cnt <= sop_cnt - 13'd1;
              if (dcnt == 13'd1) state <= (rem_dec != 13'd0) ? S_SKIP : S_CRC;
            end
            S_SKIP: begin
              crc32 <= crc32_next;
              rem   <= rem_dec;
              if (rem_dec == 13'd0) state <= S_CRC;
            end
            S_CRC: begin
              crc_rx <= {crc_rx[15:0], DATA_IN};
              cnt    <= cnt + 4'd1;
              if (cnt == 4'd3) begin
                PKT_DONE  <= 1'b1;
                CRC32_ERR <= ({crc_rx, DATA_IN} != crc32);
                CC_ERR    <= cc_bad;
                cnt       <= 4'd0;
                state     <= S_IDLE;
              end
            end
            S_IDLE:  ;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_t2mi_packets_to_ts.sv
// Self-checking bench for t2mi_packets_to_ts: builds T2-MI packets from randomized content and
// compares the TS stream and per-packet status against expectations derived from the packet layout.
module tb_t2mi_packets_to_ts;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       ENA_IN = 1'b0;
  logic       SOP_IN = 1'b0;
  logic [7:0] TS_DATA, PKT_TYPE, FRAME_IDX, PLP_ID;
  logic       TS_ENA, TS_SOP, HEM, PKT_DONE, CRC32_ERR, CRC8_ERR, FMT_ERR, CC_ERR, ABORT;
  logic [3:0] SUPERFRAME_IDX, state_mon;

  always #5 CLK = ~CLK;

  t2mi_packets_to_ts dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .SOP_IN(SOP_IN),
    .TS_DATA(TS_DATA), .TS_ENA(TS_ENA), .TS_SOP(TS_SOP), .HEM(HEM), .PKT_TYPE(PKT_TYPE),
    .FRAME_IDX(FRAME_IDX), .PLP_ID(PLP_ID), .SUPERFRAME_IDX(SUPERFRAME_IDX), .PKT_DONE(PKT_DONE),
    .CRC32_ERR(CRC32_ERR), .CRC8_ERR(CRC8_ERR), .FMT_ERR(FMT_ERR), .CC_ERR(CC_ERR),
    .ABORT(ABORT), .state_mon(state_mon)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC definitions used to build correct packets.
  function automatic logic [7:0] ref_crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'hD5;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_crc32(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // Monitor: captures the TS stream and per-packet status on the falling edge.
  typedef struct packed { logic sop; logic [7:0] d; } ts_t;
  typedef struct packed { logic crc32; logic cc; logic crc8; logic fmt; logic hem; } done_t;
  ts_t   ts_q[$];
  done_t done_q[$];
  int    n_abort = 0;
  int    n_stray_sop = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (TS_ENA) ts_q.push_back({TS_SOP, TS_DATA});
      if (!TS_ENA && TS_SOP) n_stray_sop++;
      if (PKT_DONE) done_q.push_back({CRC32_ERR, CC_ERR, CRC8_ERR, FMT_ERR, HEM});
      if (ABORT) n_abort++;
    end
  end

  task automatic clear_mon();
    ts_q.delete();
    done_q.delete();
    n_abort = 0;
  endtask

  // Packet under construction and the identifiers it carries.
  logic [7:0] pkt[$];
  logic [7:0] exp_frame, exp_plp;
  logic [3:0] exp_sf;

  task automatic build(input logic [7:0] typ, input logic [7:0] cnt, input int plen, input int dfl,
                       input int syncd, input bit hem, input bit bad8, input bit bad32);
    int pb;
    logic [7:0]  c8, sfb;
    logic [31:0] c32;
    pb  = (plen + 7) / 8;
    sfb = 8'($urandom);
    exp_sf = sfb[7:4];
    pkt.delete();
    pkt.push_back(typ); pkt.push_back(cnt); pkt.push_back(sfb); pkt.push_back(8'($urandom));
    pkt.push_back(8'(plen >> 8)); pkt.push_back(8'(plen));
    if (typ == 8'h00) begin
      exp_frame = 8'($urandom);
      exp_plp   = 8'($urandom);
      pkt.push_back(exp_frame); pkt.push_back(exp_plp); pkt.push_back(8'($urandom));
      for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
      pkt.push_back(8'(dfl >> 8)); pkt.push_back(8'(dfl));
      pkt.push_back(8'($urandom));
      pkt.push_back(8'(syncd >> 8)); pkt.push_back(8'(syncd));
      c8 = 8'h00;
      for (int i = 9; i < 18; i++) c8 = ref_crc8(c8, pkt[i]);
      pkt.push_back(c8 ^ {7'd0, hem} ^ (bad8 ? 8'h5A : 8'h00));
    end
    while (pkt.size() < 6 + pb) pkt.push_back(8'($urandom));
    c32 = 32'hFFFFFFFF;
    foreach (pkt[i]) c32 = ref_crc32(c32, pkt[i]);
    if (bad32) pkt[6] = pkt[6] ^ 8'h01;
    for (int i = 3; i >= 0; i--) pkt.push_back(c32[8*i +: 8]);
  endtask

  // Drives the first n bytes of pkt; the last byte stays on the bus so a following send is back-to-back.
  task automatic send(input int gap_pct, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        ENA_IN = 1'b0; SOP_IN = 1'b0; DATA_IN = 8'($urandom);
        @(posedge CLK); #1;
      end
      ENA_IN = 1'b1; DATA_IN = pkt[i]; SOP_IN = (i == 0);
    end
  endtask

  task automatic idle(input int n);
    @(posedge CLK); #1;
    ENA_IN = 1'b0; SOP_IN = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Continuity reference: the packet_count should advance by one, except when no history exists.
  logic [7:0] cc_prev = 8'h00;
  bit         cc_ok = 1'b0;
  task automatic cc_model(input logic [7:0] c, output bit bad);
    bad     = cc_ok && (c != 8'(cc_prev + 8'd1));
    cc_prev = c;
    cc_ok   = 1'b1;
  endtask

  // Compares the captured TS stream with the data field bytes and the expected user-packet starts.
  task automatic check_ts(input string tag, input int n_bytes, input int syncd, input bit hem);
    int upl, off, bad_d, bad_s, lim;
    bit exp_sop;
    upl = hem ? 187 : 188;
    off = syncd >> 3;
    bad_d = 0; bad_s = 0;
    lim = (ts_q.size() < n_bytes) ? ts_q.size() : n_bytes;
    check({tag, ".ts_count"}, ts_q.size(), n_bytes);
    for (int k = 0; k < lim; k++) begin
      exp_sop = (syncd != 16'hFFFF) && (k >= off) && ((k - off) % upl == 0);
      if (ts_q[k].d !== pkt[19 + k]) bad_d++;
      if (ts_q[k].sop !== exp_sop) bad_s++;
    end
    check({tag, ".ts_bytes_wrong"}, bad_d, 0);
    check({tag, ".ts_sop_wrong"}, bad_s, 0);
  endtask

  task automatic check_done(input string tag, input int idx, input bit e32, input bit ecc,
                            input bit e8, input bit efmt, input bit ehem);
    done_t d;
    if (done_q.size() > idx) d = done_q[idx];
    else                     d = 'x;
    check({tag, ".crc32_err"}, 32'(d.crc32), 32'(e32));
    check({tag, ".cc_err"},    32'(d.cc),    32'(ecc));
    check({tag, ".crc8_err"},  32'(d.crc8),  32'(e8));
    check({tag, ".fmt_err"},   32'(d.fmt),   32'(efmt));
    check({tag, ".hem"},       32'(d.hem),   32'(ehem));
  endtask

  // One BB-frame packet end to end, with expectations from the length and MODE rules.
  task automatic run_bb(input string tag, input logic [7:0] cnt, input int plen, input int dfl,
                        input int syncd, input bit hem, input bit bad8, input int gap, input int exp_abort);
    int pb, dfl_b;
    bit fmt, ecc;
    build(8'h00, cnt, plen, dfl, syncd, hem, bad8, 1'b0);
    cc_model(cnt, ecc);
    pb    = (plen + 7) / 8;
    dfl_b = dfl >> 3;
    fmt   = (pb < 13) || (dfl_b > pb - 13);
    if (pb < 13)  dfl_b = 0;
    else if (fmt) dfl_b = pb - 13;
    clear_mon();
    send(gap, pkt.size());
    idle(4);
    check_ts(tag, dfl_b, syncd, hem && !bad8);
    check({tag, ".done_count"}, done_q.size(), 1);
    check_done(tag, 0, 1'b0, ecc, bad8, fmt, hem && !bad8);
    check({tag, ".frame_idx"}, FRAME_IDX, exp_frame);
    check({tag, ".plp_id"}, PLP_ID, exp_plp);
    check({tag, ".superframe"}, SUPERFRAME_IDX, exp_sf);
    check({tag, ".pkt_type"}, PKT_TYPE, 8'h00);
    check({tag, ".abort_count"}, n_abort, exp_abort);
  endtask

  initial begin
    bit ecc0, ecc1, ecc2;
    int pb, plen, dfl, syncd;
    logic [7:0] cnt;

    repeat (3) @(posedge CLK);
    #1;
    check("reset.flags", {TS_DATA, TS_ENA, TS_SOP, HEM, PKT_DONE, CRC32_ERR, CRC8_ERR, FMT_ERR,
                          CC_ERR, ABORT, state_mon}, 32'd0);
    check("reset.ids", {PKT_TYPE, FRAME_IDX, PLP_ID, SUPERFRAME_IDX}, 32'd0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    run_bb("nm_frame", 8'd0, 7056, 6952, 0, 1'b0, 1'b0, 0, 0);
    run_bb("hem_frame", 8'd1, 7056, 6952, 800, 1'b1, 1'b0, 0, 0);

    // Timestamp then L1 packet, back-to-back: CRC-checked and discarded.
    clear_mon();
    build(8'h20, 8'd2, 88, 0, 0, 1'b0, 1'b0, 1'b0);
    cc_model(8'd2, ecc0);
    send(0, pkt.size());
    build(8'h10, 8'd3, 200, 0, 0, 1'b0, 1'b0, 1'b0);
    cc_model(8'd3, ecc1);
    send(0, pkt.size());
    idle(4);
    check("ts_l1.ts_count", ts_q.size(), 0);
    check("ts_l1.done_count", done_q.size(), 2);
    check_done("ts_pkt", 0, 1'b0, ecc0, 1'b0, 1'b0, 1'b1);
    check("l1_pkt.crc32_err", 32'(done_q.size() > 1 ? done_q[1].crc32 : 1'bx), 32'd0);
    check("l1_pkt.cc_err", 32'(done_q.size() > 1 ? done_q[1].cc : 1'bx), 32'(ecc1));
    check("l1_pkt.pkt_type", PKT_TYPE, 8'h10);
    check("l1_pkt.superframe", SUPERFRAME_IDX, exp_sf);

    // Corrupted payload byte in a timestamp packet.
    clear_mon();
    build(8'h20, 8'd4, 88, 0, 0, 1'b0, 1'b0, 1'b1);
    cc_model(8'd4, ecc0);
    send(0, pkt.size());
    idle(4);
    check("bad_crc32.done_count", done_q.size(), 1);
    check("bad_crc32.crc32_err", 32'(done_q.size() > 0 ? done_q[0].crc32 : 1'bx), 32'd1);

    // packet_count 5,6,8 back-to-back.
    clear_mon();
    build(8'h20, 8'd5, 88, 0, 0, 1'b0, 1'b0, 1'b0); cc_model(8'd5, ecc0); send(0, pkt.size());
    build(8'h20, 8'd6, 88, 0, 0, 1'b0, 1'b0, 1'b0); cc_model(8'd6, ecc1); send(0, pkt.size());
    build(8'h20, 8'd8, 88, 0, 0, 1'b0, 1'b0, 1'b0); cc_model(8'd8, ecc2); send(0, pkt.size());
    idle(4);
    check("cc_seq.done_count", done_q.size(), 3);
    check("cc_seq.cc_err_5", 32'(done_q.size() > 0 ? done_q[0].cc : 1'bx), 32'(ecc0));
    check("cc_seq.cc_err_6", 32'(done_q.size() > 1 ? done_q[1].cc : 1'bx), 32'(ecc1));
    check("cc_seq.cc_err_8", 32'(done_q.size() > 2 ? done_q[2].cc : 1'bx), 32'(ecc2));
    check("cc_seq.model_8_bad", 32'(ecc2), 32'(done_q.size() > 2 ? 1'b1 : 1'b0));

    // Truncated BB frame: 6 header + 13 BB bytes + 300 data bytes, then a fresh packet.
    clear_mon();
    build(8'h00, 8'd9, 7056, 6952, 0, 1'b0, 1'b0, 1'b0);
    cc_model(8'd9, ecc0);
    send(0, 6 + 13 + 300);
    idle(3);
    check_ts("partial", 300, 0, 1'b0);
    check("partial.done_count", done_q.size(), 0);
    check("partial.state", state_mon, 4'd4);
    cc_ok = 1'b0;
    run_bb("after_abort", 8'd200, 7056, 6952, 8 * 17, 1'b0, 1'b0, 0, 1);

    // Oversized DFL with random ENA_IN gaps: clipped to the available 869 bytes.
    run_bb("fmt_gaps", 8'd201, 7056, 8000, 0, 1'b0, 1'b0, 30, 0);

    // BBHEADER CRC-8 mismatch: data still forwarded, HEM forced to 0, flag cleared after PKT_DONE.
    run_bb("bad_crc8", 8'd202, 63 * 8, 50 * 8, 8 * 7, 1'b1, 1'b1, 20, 0);
    check("bad_crc8.cleared", CRC8_ERR, 1'b0);

    // Randomized BB frames.
    cnt = 8'd203;
    for (int r = 0; r < 6; r++) begin
      pb    = int'($urandom_range(300, 13));
      plen  = pb * 8 - int'($urandom_range(7, 0));
      dfl   = int'($urandom_range(pb - 13 + 5, 0)) * 8 + int'($urandom_range(7, 0));
      syncd = ($urandom_range(3, 0) == 0) ? 16'hFFFF : int'($urandom_range(200, 0)) * 8;
      run_bb($sformatf("rand%0d", r), cnt, plen, dfl, syncd, 1'($urandom), ($urandom_range(3, 0) == 0),
             int'($urandom_range(40, 0)), 0);
      cnt = cnt + 8'd1;
    end

    check("stray_ts_sop", n_stray_sop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
